// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline control:
// hazard FSM states, E-stage forward selects and jump kinds.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LDSTALL  = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

    localparam int NUM_OPS = 2;

    // $zero is never a real producer, so it never matches.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// E-stage operand bypass select; one instance per ALU source operand.
// A load result is not available in M, so M only forwards non-load producers.
module forwarding_unit
    import mips_pipe_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       RegWrite_M_i,
    input  logic [4:0] WriteReg_M_i,
    input  logic       MemRead_M_i,
    input  logic       RegWrite_W_i,
    input  logic [4:0] WriteReg_W_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (RegWrite_M_i && reg_hit(WriteReg_M_i, src_i) && !MemRead_M_i)
            fwd_o = FWD_MEM;
        else if (RegWrite_W_i && reg_hit(WriteReg_W_i, src_i))
            fwd_o = FWD_WB;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, redirect squash, E-stage forwarding
// selects and wrapping debug counters. Controls act at the same clock edge.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           Rs_D,
    input  logic [4:0]           Rt_D,
    input  logic [4:0]           Rs_E,
    input  logic [4:0]           Rt_E,
    input  logic                 MemRead_E,
    input  logic                 RegWrite_E,
    input  logic [4:0]           WriteReg_E,
    input  logic                 RegWrite_M,
    input  logic [4:0]           WriteReg_M,
    input  logic                 MemRead_M,
    input  logic                 RegWrite_W,
    input  logic [4:0]           WriteReg_W,
    input  logic                 BranchTaken_M,
    input  logic [1:0]           Jump_M,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic [1:0]           ForwardA_E,
    output logic [1:0]           ForwardB_E,
    output logic [1:0]           State,
    output logic [CNT_WIDTH-1:0] CycleCnt,
    output logic [CNT_WIDTH-1:0] StallCnt,
    output logic [CNT_WIDTH-1:0] FlushCnt
);

    hz_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cyc_q, stall_q, flush_q;
    logic                 load_use, redirect;
    logic [NUM_OPS-1:0][4:0] fwd_src;
    logic [NUM_OPS-1:0][1:0] fwd_sel;

    assign load_use = MemRead_E && RegWrite_E &&
                      (reg_hit(WriteReg_E, Rs_D) || reg_hit(WriteReg_E, Rt_D));
    assign redirect = BranchTaken_M || (Jump_M != JMP_NONE);

    // Redirect wins over load-use; load-use is only seen from RUN
    // (and from the unused encoding, which behaves as RUN).
    always_comb begin
        state_d = ST_RUN;
        StallF  = 1'b0;
        StallD  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        if (!reset) begin
            if (redirect) begin
                FlushD  = 1'b1;
                FlushE  = 1'b1;
                FlushM  = 1'b1;
                state_d = ST_REDIRECT;
            end else if (load_use && state_q != ST_LDSTALL && state_q != ST_REDIRECT) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                FlushE  = 1'b1;
                state_d = ST_LDSTALL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_q + 1'b1;
            stall_q <= stall_q + {{(CNT_WIDTH-1){1'b0}}, StallF};
            flush_q <= flush_q + {{(CNT_WIDTH-1){1'b0}}, FlushM};
        end
    end

    assign fwd_src[0] = Rs_E;
    assign fwd_src[1] = Rt_E;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        forwarding_unit u_fwd (
            .src_i        (fwd_src[i]),
            .RegWrite_M_i (RegWrite_M),
            .WriteReg_M_i (WriteReg_M),
            .MemRead_M_i  (MemRead_M),
            .RegWrite_W_i (RegWrite_W),
            .WriteReg_W_i (WriteReg_W),
            .fwd_o        (fwd_sel[i])
        );
    end

    assign ForwardA_E = reset ? FWD_RF : fwd_sel[0];
    assign ForwardB_E = reset ? FWD_RF : fwd_sel[1];
    assign State      = state_q;
    assign CycleCnt   = cyc_q;
    assign StallCnt   = stall_q;
    assign FlushCnt   = flush_q;

endmodule
